tx_payload_sequencer: RTL and testbench
=======================================

Name: tx_payload_sequencer

Overview:
- Sits in the clk125MHz domain, directly downstream of the dual-VRAM / bram_1080 memory-control stage.
- Drives the VRAM port-B pixel address, the per-pixel byte select and the bram_1080 write/read counters.
- Collects the returned bytes into a registered 1-byte-per-cycle payload stream for the Ethernet frame builder.
- One start pulse sends one segment of BYTES_PER_SEG payload bytes. For txid==1 the bytes are also copied into bram_1080; for other IDs the bytes are replayed from bram_1080.

Parameters:
PIXELS_PER_SEG, 360, pixels per segment; bytes per segment = 3*PIXELS_PER_SEG = 1080
VRAM_AW, 24, VRAM port-B address width
CNT_W, 13, bram_1080 address width

Ports:
clk125MHz  in  1  Ethernet tx clock; the only clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to send one segment; ignored while busy
txid  in  1  transmitter ID; latched at start; 1 = first transmission
segment_num  in  8  segment index; latched at start
din_first  in  8  byte selected from the VRAMs by vramaddr_c (1-cycle read latency)
din_not_first  in  8  byte from bram_1080 port B (1-cycle read latency)
vram_addrb  out  VRAM_AW  VRAM port-B pixel address
vramaddr_c  out  3  byte select for the current byte: 0 = R, 1 = B, 2 = G
count_for_bram  out  CNT_W  bram_1080 write address
count_for_bram_b  out  CNT_W  bram_1080 read address
count_for_bram_en  out  1  bram_1080 write enable
dout  out  8  payload byte
dout_valid  out  1  dout qualifier
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last valid byte

Behaviour:
- Reset values:
  - State is IDLE.
  - Every output is 0, including busy, done, dout_valid, count_for_bram_en and all addresses.
- Reset mid-segment: abort immediately with no further valid bytes. Any partial bram_1080 contents are don't-care.
- States:
  - IDLE: start=1 latches txid and segment_num, clears the byte counter b and pixel counter p, sets busy=1, then goes to READ.
  - READ: issues one byte per cycle for b = 0 .. 3*PIXELS_PER_SEG-1. After issuing the last byte, goes to DRAIN.
  - DRAIN: waits 2 cycles for the pipeline to empty, then goes to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE. A start seen in the DONE cycle is ignored.
- Issue in READ cycle t:
  - vram_addrb = segment_num*PIXELS_PER_SEG + p. Use an unsigned multiply into VRAM_AW bits; the maximum is 255*360+359 = 92159, so there is no wrap.
  - count_for_bram_b = b.
  - The in-pixel byte counter c steps 0→1→2→0; p increments when c wraps from 2.
  - vram_addrb is held constant for all three bytes of a pixel.
- Alignment stage, cycle t+1 (read data present):
  - vramaddr_c = c of issue t.
  - count_for_bram = b of issue t.
  - count_for_bram_en = 1 only if the latched txid==1.
- Output stage, cycle t+2:
  - dout = (txid==1) ? din_first : din_not_first, as sampled at the end of t+1.
  - dout_valid = 1.
- Latency and timing:
  - Issue-to-dout latency is 2 cycles.
  - No gaps: dout_valid stays high for exactly 1080 consecutive cycles.
  - The first dout_valid comes 3 cycles after the start cycle (IDLE→READ takes 1 cycle).
  - done asserts the cycle after the last dout_valid.
- Outside the valid windows:
  - count_for_bram_en = 0 and dout_valid = 0.
  - Addresses and vramaddr_c hold their last value. Returning them to 0 is also allowed; verification must not check them when unqualified.
- txid==0: bram_1080 is never written, and din_first is ignored.
- There is no backpressure; the consumer must accept 1 byte per cycle.

Test Plan:
- Reset values: hold rst for 3 cycles → all outputs 0, busy=0.
- First-ID segment: txid=1, segment_num=2, VRAM model holds R=addr[7:0], B=addr[7:0]+1, G=addr[7:0]+2.
  - vram_addrb runs 720..1079, each value held 3 cycles.
  - First bytes are 0xD0, 0xD1, 0xD2; vramaddr_c sequence is 0,1,2.
  - count_for_bram_en is high for 1080 cycles with count_for_bram 0..1079.
  - done fires 1 cycle after the 1080th valid byte.
- Replay: txid=0 after the previous test, bram_1080 model preloaded → dout equals the bram contents in order 0..1079, and count_for_bram_en stays 0 throughout.
- Start while busy: pulse start at byte 500 of a segment → ignored; exactly 1080 valid bytes and one done pulse.
- Reset mid-segment: assert rst at byte 300 → dout_valid=0 and busy=0 the next cycle. A new start then produces a full, correct segment.
- Max segment: segment_num=255 → last vram_addrb is 92159 with no truncation.

Source files
------------

// File: rtl/tx_payload_sequencer.sv
// tx_payload_sequencer: issues VRAM/bram_1080 reads for one segment and streams the returned bytes as payload
module tx_payload_sequencer #(
  parameter int PIXELS_PER_SEG = 360,
  parameter int VRAM_AW        = 24,
  parameter int CNT_W          = 13
) (
  input  logic               clk125MHz,
  input  logic               rst,
  input  logic               start,
  input  logic               txid,
  input  logic [7:0]         segment_num,
  input  logic [7:0]         din_first,
  input  logic [7:0]         din_not_first,
  output logic [VRAM_AW-1:0] vram_addrb,
  output logic [2:0]         vramaddr_c,
  output logic [CNT_W-1:0]   count_for_bram,
  output logic [CNT_W-1:0]   count_for_bram_b,
  output logic               count_for_bram_en,
  output logic [7:0]         dout,
  output logic               dout_valid,
  output logic               busy,
  output logic               done
);
  localparam int BYTES = 3 * PIXELS_PER_SEG;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t             r_state, w_next;
  logic               r_txid, r_drain, r_al_valid, r_dv;
  logic [VRAM_AW-1:0] r_vaddr;
  logic [CNT_W-1:0]   r_b, r_cnt_al;
  logic [1:0]         r_c;
  logic [2:0]         r_c_al;
  logic [7:0]         r_dout;
  logic               w_last;
  assign w_last            = r_b == CNT_W'(BYTES - 1);
  assign vram_addrb        = r_vaddr;
  assign count_for_bram_b  = r_b;
  assign vramaddr_c        = r_c_al;
  assign count_for_bram    = r_cnt_al;
  assign count_for_bram_en = r_al_valid & r_txid;
  assign dout              = r_dout;
  assign dout_valid        = r_dv;
  assign busy              = r_state == READ || r_state == DRAIN;
  assign done              = r_state == DONE;
  // next state: IDLE -> READ (1080 issues) -> DRAIN (2 cycles) -> DONE (1 cycle)
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? READ : IDLE;
      READ:    w_next = w_last ? DRAIN : READ;
      DRAIN:   w_next = r_drain ? DONE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk125MHz) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // issue counters, alignment stage and registered payload output
  always_ff @(posedge clk125MHz) begin
    if (rst) begin
      r_txid     <= 1'b0;
      r_vaddr    <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_drain    <= 1'b0;
      r_al_valid <= 1'b0;
      r_c_al     <= '0;
      r_cnt_al   <= '0;
      r_dv       <= 1'b0;
      r_dout     <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_txid  <= txid;
        r_vaddr <= VRAM_AW'(segment_num) * VRAM_AW'(PIXELS_PER_SEG);
        r_b     <= '0;
        r_c     <= '0;
      end else if (r_state == READ) begin
        r_b <= w_last ? r_b : r_b + 1'b1;
        r_c <= r_c == 2'd2 ? 2'd0 : r_c + 2'd1;
        if (r_c == 2'd2 && !w_last) r_vaddr <= r_vaddr + 1'b1;
      end
      r_drain    <= r_state == DRAIN && !r_drain;
      r_al_valid <= r_state == READ;
      if (r_state == READ) begin
        r_c_al   <= {1'b0, r_c};
        r_cnt_al <= r_b;
      end
      r_dv   <= r_al_valid;
      r_dout <= r_txid ? din_first : din_not_first;
    end
  end
endmodule

// File: tb/tb_tx_payload_sequencer.sv
// tb_tx_payload_sequencer: scenario table plus random segments against a VRAM/bram_1080 environment model
module tb_tx_payload_sequencer;
  localparam int PPS = 360, AW = 24, CW = 13, NB = 1080;
  logic          clk = 1'b0;
  logic          rst, start, txid;
  logic [7:0]    segment_num, din_first, din_not_first;
  logic [AW-1:0] vram_addrb;
  logic [2:0]    vramaddr_c;
  logic [CW-1:0] count_for_bram, count_for_bram_b;
  logic          count_for_bram_en, dout_valid, busy, done;
  logic [7:0]    dout;
  int            checks = 0, errors = 0;
  logic [AW-1:0] r_pix;
  logic [7:0]    r_bq;
  logic [7:0]    bram [NB];
  logic          ld;
  logic [CW-1:0] ld_a;
  logic [7:0]    ld_d, salt;
  logic [7:0]    ref_bram [NB];
  bit            ref_ok = 0;
  logic [7:0]    fb [3];
  int            lastv;

  typedef struct {
    bit tx;
    int seg;
    int slt;
    int extra;
    int rk;
    bit pre;
    int exp_last;
  } vec_t;

  always #4 clk = ~clk;

  tx_payload_sequencer #(.PIXELS_PER_SEG(PPS), .VRAM_AW(AW), .CNT_W(CW)) dut (
    .clk125MHz(clk), .rst(rst), .start(start), .txid(txid), .segment_num(segment_num),
    .din_first(din_first), .din_not_first(din_not_first), .vram_addrb(vram_addrb),
    .vramaddr_c(vramaddr_c), .count_for_bram(count_for_bram), .count_for_bram_b(count_for_bram_b),
    .count_for_bram_en(count_for_bram_en), .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done)
  );

  function automatic logic [7:0] vb(input int a, input int c);
    return 8'(a + c + int'(salt));
  endfunction

  always @(posedge clk) begin
    r_pix <= vram_addrb;
    if (count_for_bram_b < CW'(NB)) r_bq <= bram[count_for_bram_b];
    if (ld) bram[ld_a] <= ld_d;
    else if (count_for_bram_en && count_for_bram < CW'(NB)) bram[count_for_bram] <= din_first;
  end
  assign din_first     = vb(int'(r_pix), int'(vramaddr_c));
  assign din_not_first = r_bq;

  task automatic chk(input string nm, input int n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, n, a, e);
    end
  endtask

  task automatic preload();
    for (int k = 0; k < NB; k++) begin
      ld = 1'b1;
      ld_a = CW'(k);
      ld_d = 8'($urandom);
      ref_bram[k] = ld_d;
      @(posedge clk); #1;
    end
    ld = 1'b0;
    ref_ok = 1;
  endtask

  task automatic run_seg(input bit tx, input logic [7:0] seg, input int extra, input int rk);
    logic [7:0] exp [NB];
    int nv = 0, nd = 0;
    for (int k = 0; k < NB; k++) exp[k] = tx ? vb(int'(seg) * PPS + k / 3, k % 3) : ref_bram[k];
    txid = tx;
    segment_num = seg;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    txid = ~tx;
    segment_num = 8'($urandom);
    for (int n = 1; n <= 1090; n++) begin
      if (n <= NB) begin
        chk("vram_addrb", n, 32'(vram_addrb), 32'(int'(seg) * PPS + (n - 1) / 3));
        chk("count_for_bram_b", n, 32'(count_for_bram_b), 32'(n - 1));
        if (n == NB) lastv = int'(vram_addrb);
      end
      if (n >= 2 && n <= NB + 1) begin
        chk("vramaddr_c", n, 32'(vramaddr_c), 32'((n - 2) % 3));
        chk("count_for_bram_en", n, 32'(count_for_bram_en), 32'(tx));
        if (tx) chk("count_for_bram", n, 32'(count_for_bram), 32'(n - 2));
      end else chk("count_for_bram_en_idle", n, 32'(count_for_bram_en), 0);
      if (n >= 3 && n <= NB + 2) begin
        chk("dout_valid", n, 32'(dout_valid), 1);
        chk("dout", n, 32'(dout), 32'(exp[n - 3]));
        if (n - 3 < 3) fb[n - 3] = dout;
      end else chk("dout_valid_idle", n, 32'(dout_valid), 0);
      chk("busy", n, 32'(busy), 32'(n <= NB + 2));
      chk("done", n, 32'(done), 32'(n == NB + 3));
      nv += int'(dout_valid);
      nd += int'(done);
      if (rk >= 0 && n == 3 + rk) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_dout_valid", n, 32'(dout_valid), 0);
        chk("rst_busy", n, 32'(busy), 0);
        chk("rst_done", n, 32'(done), 0);
        chk("rst_en", n, 32'(count_for_bram_en), 0);
        if (tx) ref_ok = 0;
        return;
      end
      start = extra >= 0 && n == 3 + extra;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("valid_count", 0, 32'(nv), NB);
    chk("done_count", 0, 32'(nd), 1);
    if (tx) begin
      for (int k = 0; k < NB; k++) ref_bram[k] = exp[k];
      ref_ok = 1;
    end
  endtask

  initial begin
    vec_t tbl [8];
    tbl[0] = '{1'b1, 2,   0,     -1,   -1,  1'b0, 1079};
    tbl[1] = '{1'b0, 7,   0,     -1,   -1,  1'b0, 2879};
    tbl[2] = '{1'b0, 9,   0,     -1,   -1,  1'b1, 3599};
    tbl[3] = '{1'b1, 255, 8'h5A, 500,  -1,  1'b0, 92159};
    tbl[4] = '{1'b0, 3,   0,     1080, -1,  1'b0, 1439};
    tbl[5] = '{1'b1, 40,  8'h33, -1,   300, 1'b0, 0};
    tbl[6] = '{1'b1, 41,  8'h77, -1,   -1,  1'b0, 15119};
    tbl[7] = '{1'b0, 0,   0,     -1,   -1,  1'b0, 359};
    rst = 1'b1; start = 1'b0; txid = 1'b0; segment_num = '0;
    ld = 1'b0; ld_a = '0; ld_d = '0; salt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vram_addrb", 0, 32'(vram_addrb), 0);
    chk("rst_vramaddr_c", 0, 32'(vramaddr_c), 0);
    chk("rst_count_for_bram", 0, 32'(count_for_bram), 0);
    chk("rst_count_for_bram_b", 0, 32'(count_for_bram_b), 0);
    chk("rst_count_for_bram_en", 0, 32'(count_for_bram_en), 0);
    chk("rst_dout", 0, 32'(dout), 0);
    chk("rst_dout_valid", 0, 32'(dout_valid), 0);
    chk("rst_busy", 0, 32'(busy), 0);
    chk("rst_done", 0, 32'(done), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", 0, 32'(busy), 0);
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].pre || (!tbl[i].tx && !ref_ok)) preload();
      salt = 8'(tbl[i].slt);
      run_seg(tbl[i].tx, 8'(tbl[i].seg), tbl[i].extra, tbl[i].rk);
      if (tbl[i].rk < 0) chk("last_vram_addrb", i, 32'(lastv), 32'(tbl[i].exp_last));
      if (i == 0) begin
        chk("first_byte0", 0, 32'(fb[0]), 32'h D0);
        chk("first_byte1", 0, 32'(fb[1]), 32'h D1);
        chk("first_byte2", 0, 32'(fb[2]), 32'h D2);
      end
      repeat (2) @(posedge clk);
      #1;
    end
    for (int r = 0; r < 4; r++) begin
      bit tx;
      tx = 1'($urandom_range(0, 1));
      if (!tx && (!ref_ok || $urandom_range(0, 1) == 1)) preload();
      salt = 8'($urandom);
      run_seg(tx, 8'($urandom_range(0, 255)), -1, -1);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
